mem_req_arbiter: RTL and testbench
==================================

// Module: mem_req_arbiter
// PURPOSE
//  Round-robin arbiter sharing the single flash transaction FSM command port among NUM_REQ crypto requesters (key/text fetch, result write).
//  Latches one winner and forwards its command. Routes write/read data only between that winner and the FSM.
//  Holds the grant until status reports op done or a grant watchdog expires. Sits between the crypto cores and the transaction FSM.
// PARAMETERS
//  NUM_REQ     2      number of requesters (2..4); GW = $clog2(NUM_REQ), min 1
//  TIMEOUT_CYC 4096   max cycles a grant may be held after command acceptance (>=2)
// PORTS
//  clk                 in   1           clock
//  rst_n               in   1           synchronous active-low reset
//  in_req_valid        in   NUM_REQ     per-requester command valid (level, held until out_req_ack)
//  in_req_opcode       in   2*NUM_REQ   per-requester opcode, slice i = [2i+1:2i]
//  in_req_addr         in   24*NUM_REQ  per-requester 24-bit flash address
//  out_req_ack         out  NUM_REQ     1-cycle pulse: command accepted by FSM
//  out_req_done        out  NUM_REQ     1-cycle pulse: transaction completed
//  out_req_err         out  NUM_REQ     1-cycle pulse: grant watchdog expired
//  in_req_wr_valid     in   NUM_REQ     write-data valid
//  in_req_wr_data      in   8*NUM_REQ   write data
//  out_req_wr_ready    out  NUM_REQ     write-data ready (granted requester only)
//  out_req_rd_valid    out  NUM_REQ     read-data valid (granted requester only)
//  out_req_rd_data     out  8           read data (shared bus, qualify with rd_valid)
//  in_req_rd_ready     in   NUM_REQ     read-data ready
//  out_cmd_valid       out  1           to FSM command valid
//  out_cmd_opcode      out  2           to FSM opcode
//  out_cmd_addr        out  24          to FSM address
//  in_fsm_cmd_ready    in   1           FSM command accept pulse
//  out_wr_data_valid   out  1           to FSM write-data valid
//  out_wr_data         out  8           to FSM write data
//  in_fsm_data_ready   in   1           FSM write-data ready
//  in_rd_data_valid    in   1           FSM read-data valid
//  in_rd_data          in   8           FSM read data
//  out_rd_ready        out  1           to FSM read-data ready
//  in_op_done          in   1           status op-done (level or pulse)
//  out_grant           out  GW          current/last granted index
//  out_busy            out  1           1 in any state except ARB
// BEHAVIOUR
//  Reset (rst_n low at posedge):
//   - state=ARB; rr_ptr=0; grant=0; timer=0.
//   - All valid/ready/ack/done/err outputs 0; out_cmd_opcode/addr=0.
//   - Reset mid-operation abandons the grant without done/err pulses.
//  ARB: scan in_req_valid starting at rr_ptr, wrapping modulo NUM_REQ.
//   - First set bit wins: grant<=index, latch its opcode/addr into out_cmd_*, out_cmd_valid<=1, go ISSUE.
//   - No requester valid: stay in ARB.
//   - Winner is latched; later changes on in_req_* do not affect the issued command.
//  ISSUE: hold out_cmd_valid and out_cmd_* stable until in_fsm_cmd_ready=1.
//   - On that cycle: out_cmd_valid<=0, out_req_ack[grant] pulse next cycle, timer<=0, go BUSY.
//   - No timeout in ISSUE (FSM may still be booting).
//  BUSY: timer increments every cycle, saturating at TIMEOUT_CYC.
//   - in_op_done=1: out_req_done[grant] pulse, go RELEASE.
//   - Else if timer==TIMEOUT_CYC-1: out_req_err[grant] pulse, go RELEASE.
//   - in_op_done and timeout in the same cycle: done wins, no err.
//  RELEASE (1 cycle): rr_ptr<=(grant+1) mod NUM_REQ, go ARB.
//   - Gap guarantees a new command never overlaps FSM S_FINISH->IDLE.
//  Data routing (combinational from grant, active only in BUSY):
//   - out_wr_data_valid = in_req_wr_valid[grant]; out_wr_data = slice grant.
//   - out_req_wr_ready[grant] = in_fsm_data_ready; out_req_rd_valid[grant] = in_rd_data_valid.
//   - out_rd_ready = in_req_rd_ready[grant]; out_req_rd_data = in_rd_data.
//   - Non-granted wr_ready/rd_valid=0.
//   - Outside BUSY: out_wr_data_valid=0, out_rd_ready=0.
//  Fairness: a requester re-asserting immediately after done waits behind all other pending requesters.
//  Latency: request seen in ARB -> out_cmd_valid next cycle.
// TESTING
//  1 Reset: rst_n=0 two cycles, all inputs high -> all outputs 0, out_busy=0.
//  2 Single req: req0 op=2'b00 addr=24'h001000, FSM ready after 3 cycles -> cmd held 3 cycles; ack0 pulse; rd byte 8'hA5 reaches req0 only; op_done -> done0; busy low 2 cycles later.
//  3 Round robin: req0,req1 held valid continuously, 4 ops -> grants 0,1,0,1; ack/done pulses match grant.
//  4 Write routing: grant=1 op=2'b10 data 8'h3C -> out_wr_data=8'h3C; wr_ready reaches req1 only; req0 wr_valid ignored.
//  5 Timeout: TIMEOUT_CYC=16, no op_done -> err pulse exactly 16 cycles after ack cycle; no done; next requester granted.
//  6 Collision/reset: op_done on timeout cycle -> done only; rst_n low during BUSY -> ARB, no pulses, rr_ptr=0.

Source files
------------

// File: rtl/mem_req_arbiter.sv
// rtl/mem_req_arbiter.sv - round-robin arbiter granting the flash transaction FSM to one crypto requester
module mem_req_arbiter #(
  parameter int NUM_REQ     = 2,
  parameter int TIMEOUT_CYC = 4096,
  localparam int GW         = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [NUM_REQ-1:0]    in_req_valid,
  input  logic [2*NUM_REQ-1:0]  in_req_opcode,
  input  logic [24*NUM_REQ-1:0] in_req_addr,
  output logic [NUM_REQ-1:0]    out_req_ack,
  output logic [NUM_REQ-1:0]    out_req_done,
  output logic [NUM_REQ-1:0]    out_req_err,
  input  logic [NUM_REQ-1:0]    in_req_wr_valid,
  input  logic [8*NUM_REQ-1:0]  in_req_wr_data,
  output logic [NUM_REQ-1:0]    out_req_wr_ready,
  output logic [NUM_REQ-1:0]    out_req_rd_valid,
  output logic [7:0]            out_req_rd_data,
  input  logic [NUM_REQ-1:0]    in_req_rd_ready,
  output logic                  out_cmd_valid,
  output logic [1:0]            out_cmd_opcode,
  output logic [23:0]           out_cmd_addr,
  input  logic                  in_fsm_cmd_ready,
  output logic                  out_wr_data_valid,
  output logic [7:0]            out_wr_data,
  input  logic                  in_fsm_data_ready,
  input  logic                  in_rd_data_valid,
  input  logic [7:0]            in_rd_data,
  output logic                  out_rd_ready,
  input  logic                  in_op_done,
  output logic [GW-1:0]         out_grant,
  output logic                  out_busy
);
  localparam int TW = $clog2(TIMEOUT_CYC + 1);
  localparam logic [TW-1:0] TIMER_MAX    = TW'(TIMEOUT_CYC);
  localparam logic [TW-1:0] TIMER_EXPIRE = TW'(TIMEOUT_CYC - 1);
  localparam logic [GW-1:0] LAST_IDX     = GW'(NUM_REQ - 1);

  typedef enum logic [1:0] {ST_ARB, ST_ISSUE, ST_BUSY, ST_RELEASE} state_t;

  state_t               state;
  logic [GW-1:0]        rr_ptr;
  logic [GW-1:0]        grant;
  logic [TW-1:0]        timer;
  logic [NUM_REQ-1:0]   grant_onehot;
  logic                 busy_st;
  logic                 win_found;
  logic [GW-1:0]        win_idx;
  logic [1:0]           win_opcode;
  logic [23:0]          win_addr;
  int                   win_dist;
  int                   cand_dist;

  // Winner is the valid requester with the smallest forward distance from rr_ptr.
  always_comb begin
    win_found = 1'b0;
    win_idx   = '0;
    win_dist  = NUM_REQ;
    cand_dist = 0;
    for (int i = 0; i < NUM_REQ; i++) begin
      cand_dist = i - int'(rr_ptr);
      if (cand_dist < 0) cand_dist = cand_dist + NUM_REQ;
      if (in_req_valid[i] && (cand_dist < win_dist)) begin
        win_found = 1'b1;
        win_idx   = GW'(i);
        win_dist  = cand_dist;
      end
    end
  end

  always_comb begin
    win_opcode = '0;
    win_addr   = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (win_idx == GW'(i)) begin
        win_opcode = in_req_opcode[2*i +: 2];
        win_addr   = in_req_addr[24*i +: 24];
      end
    end
  end

  always_comb begin
    grant_onehot = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      grant_onehot[i] = (grant == GW'(i));
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state          <= ST_ARB;
      rr_ptr         <= '0;
      grant          <= '0;
      timer          <= '0;
      out_cmd_valid  <= 1'b0;
      out_cmd_opcode <= '0;
      out_cmd_addr   <= '0;
      out_req_ack    <= '0;
      out_req_done   <= '0;
      out_req_err    <= '0;
    end else begin
      out_req_ack  <= '0;
      out_req_done <= '0;
      out_req_err  <= '0;
      case (state)
        ST_ARB: begin
          if (win_found) begin
            grant          <= win_idx;
            out_cmd_opcode <= win_opcode;
            out_cmd_addr   <= win_addr;
            out_cmd_valid  <= 1'b1;
            state          <= ST_ISSUE;
          end
        end
        // The FSM may still be booting, so no watchdog while waiting for acceptance.
        ST_ISSUE: begin
          if (in_fsm_cmd_ready) begin
            out_cmd_valid <= 1'b0;
            out_req_ack   <= grant_onehot;
            timer         <= '0;
            state         <= ST_BUSY;
          end
        end
        ST_BUSY: begin
          if (timer != TIMER_MAX) timer <= timer + TW'(1);
          if (in_op_done) begin
            out_req_done <= grant_onehot;
            state        <= ST_RELEASE;
          end else if (timer == TIMER_EXPIRE) begin
            out_req_err <= grant_onehot;
            state       <= ST_RELEASE;
          end
        end
        ST_RELEASE: begin
          rr_ptr <= (grant == LAST_IDX) ? '0 : grant + GW'(1);
          state  <= ST_ARB;
        end
        default: state <= ST_ARB;
      endcase
    end
  end

  assign busy_st = (state == ST_BUSY);

  always_comb begin
    out_wr_data_valid = 1'b0;
    out_wr_data       = '0;
    out_rd_ready      = 1'b0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (busy_st && grant_onehot[i]) begin
        out_wr_data_valid = in_req_wr_valid[i];
        out_wr_data       = in_req_wr_data[8*i +: 8];
        out_rd_ready      = in_req_rd_ready[i];
      end
    end
  end

  assign out_req_wr_ready = (busy_st && in_fsm_data_ready) ? grant_onehot : '0;
  assign out_req_rd_valid = (busy_st && in_rd_data_valid) ? grant_onehot : '0;
  assign out_req_rd_data  = in_rd_data;
  assign out_grant        = grant;
  assign out_busy         = (state != ST_ARB);

endmodule

// File: tb/tb_mem_req_arbiter.sv
// tb/tb_mem_req_arbiter.sv - directed and randomized bench for mem_req_arbiter
module tb_mem_req_arbiter;
  localparam int N  = 3;
  localparam int TO = 16;
  localparam int GW = 2;

  logic            clk = 1'b0;
  logic            rst_n;
  logic [N-1:0]    in_req_valid;
  logic [2*N-1:0]  in_req_opcode;
  logic [24*N-1:0] in_req_addr;
  logic [N-1:0]    out_req_ack, out_req_done, out_req_err;
  logic [N-1:0]    in_req_wr_valid;
  logic [8*N-1:0]  in_req_wr_data;
  logic [N-1:0]    out_req_wr_ready, out_req_rd_valid;
  logic [7:0]      out_req_rd_data;
  logic [N-1:0]    in_req_rd_ready;
  logic            out_cmd_valid;
  logic [1:0]      out_cmd_opcode;
  logic [23:0]     out_cmd_addr;
  logic            in_fsm_cmd_ready;
  logic            out_wr_data_valid;
  logic [7:0]      out_wr_data;
  logic            in_fsm_data_ready;
  logic            in_rd_data_valid;
  logic [7:0]      in_rd_data;
  logic            out_rd_ready;
  logic            in_op_done;
  logic [GW-1:0]   out_grant;
  logic            out_busy;

  int checks   = 0;
  int failures = 0;
  int model_ptr;
  int exp_idx;
  logic [1:0]  req_op   [N];
  logic [23:0] req_addr [N];

  always #5 clk = ~clk;

  mem_req_arbiter #(.NUM_REQ(N), .TIMEOUT_CYC(TO)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_req_valid(in_req_valid), .in_req_opcode(in_req_opcode), .in_req_addr(in_req_addr),
    .out_req_ack(out_req_ack), .out_req_done(out_req_done), .out_req_err(out_req_err),
    .in_req_wr_valid(in_req_wr_valid), .in_req_wr_data(in_req_wr_data),
    .out_req_wr_ready(out_req_wr_ready), .out_req_rd_valid(out_req_rd_valid),
    .out_req_rd_data(out_req_rd_data), .in_req_rd_ready(in_req_rd_ready),
    .out_cmd_valid(out_cmd_valid), .out_cmd_opcode(out_cmd_opcode), .out_cmd_addr(out_cmd_addr),
    .in_fsm_cmd_ready(in_fsm_cmd_ready), .out_wr_data_valid(out_wr_data_valid),
    .out_wr_data(out_wr_data), .in_fsm_data_ready(in_fsm_data_ready),
    .in_rd_data_valid(in_rd_data_valid), .in_rd_data(in_rd_data), .out_rd_ready(out_rd_ready),
    .in_op_done(in_op_done), .out_grant(out_grant), .out_busy(out_busy)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic int rr_pick(input int ptr, input logic [N-1:0] mask);
    for (int k = 0; k < N; k++) begin
      if (mask[(ptr + k) % N]) return (ptr + k) % N;
    end
    return -1;
  endfunction

  function automatic logic [N-1:0] onehot(input int i);
    return N'(1) << i;
  endfunction

  task automatic set_req(input int i, input logic [1:0] op, input logic [23:0] addr);
    req_op[i]   = op;
    req_addr[i] = addr;
    in_req_opcode[2*i +: 2] = op;
    in_req_addr[24*i +: 24] = addr;
  endtask

  task automatic drive_pins();
    for (int i = 0; i < N; i++) begin
      in_req_opcode[2*i +: 2] = req_op[i];
      in_req_addr[24*i +: 24] = req_addr[i];
    end
  endtask

  task automatic rand_route();
    in_req_wr_valid   = N'($urandom);
    in_req_wr_data    = (8*N)'({$urandom, $urandom});
    in_req_rd_ready   = N'($urandom);
    in_fsm_data_ready = 1'($urandom);
    in_rd_data_valid  = 1'($urandom);
    in_rd_data        = 8'($urandom);
  endtask

  task automatic check_route(input string tag, input int exp);
    #1;
    chk({tag, "_wr_valid"}, out_wr_data_valid, in_req_wr_valid[exp]);
    chk({tag, "_wr_data"},  out_wr_data, in_req_wr_data[8*exp +: 8]);
    chk({tag, "_wr_ready"}, out_req_wr_ready, in_fsm_data_ready ? onehot(exp) : '0);
    chk({tag, "_rd_valid"}, out_req_rd_valid, in_rd_data_valid ? onehot(exp) : '0);
    chk({tag, "_rd_ready"}, out_rd_ready, in_req_rd_ready[exp]);
    chk({tag, "_rd_data"},  out_req_rd_data, in_rd_data);
  endtask

  task automatic check_idle_route(input string tag);
    #1;
    chk({tag, "_idle_route"},
        {out_wr_data_valid, out_rd_ready, out_req_wr_ready, out_req_rd_valid}, '0);
  endtask

  // From ARB with requests already driven: command out, hold, accept, ack.
  task automatic start_cmd(input string tag, input int exp, input int ready_delay, input bit drop_on_ack);
    int held;
    step();
    chk({tag, "_cmd_valid"}, out_cmd_valid, 1'b1);
    chk({tag, "_grant"},     out_grant, exp);
    chk({tag, "_opcode"},    out_cmd_opcode, req_op[exp]);
    chk({tag, "_addr"},      out_cmd_addr, req_addr[exp]);
    chk({tag, "_busy"},      out_busy, 1'b1);
    rand_route();
    check_idle_route(tag);
    held = 1;
    for (int d = 0; d < ready_delay; d++) begin
      in_req_addr   = ~in_req_addr;
      in_req_opcode = ~in_req_opcode;
      step();
      if (out_cmd_valid === 1'b1 && out_cmd_addr === req_addr[exp] && out_cmd_opcode === req_op[exp])
        held++;
    end
    drive_pins();
    chk({tag, "_cmd_held"}, held, ready_delay + 1);
    in_fsm_cmd_ready = 1'b1;
    step();
    in_fsm_cmd_ready = 1'b0;
    chk({tag, "_ack"}, out_req_ack, onehot(exp));
    chk({tag, "_cmd_drop"}, out_cmd_valid, 1'b0);
    if (drop_on_ack) in_req_valid[exp] = 1'b0;
  endtask

  // done_at = BUSY cycle index (0 = ack cycle) where op_done is raised, -1 for none.
  task automatic finish_busy(input string tag, input int exp, input int done_at);
    bit early;
    int c;
    check_route(tag, exp);
    early = 1'b0;
    for (c = 0; c <= TO; c++) begin
      in_op_done = (c == done_at);
      step();
      if (c == done_at || c == TO - 1) break;
      if (out_req_done !== '0 || out_req_err !== '0 || out_req_ack !== '0 || out_busy !== 1'b1)
        early = 1'b1;
    end
    in_op_done = 1'b0;
    chk({tag, "_no_early_pulse"}, early, 1'b0);
    chk({tag, "_done"}, out_req_done, (c == done_at) ? onehot(exp) : '0);
    chk({tag, "_err"},  out_req_err,  (c == done_at) ? '0 : onehot(exp));
    chk({tag, "_release_busy"}, out_busy, 1'b1);
    step();
    chk({tag, "_idle_busy"}, out_busy, 1'b0);
    model_ptr = (exp + 1) % N;
  endtask

  initial begin
    rst_n = 1'b0;
    in_req_valid = '1; in_req_opcode = '1; in_req_addr = '1;
    in_req_wr_valid = '1; in_req_wr_data = '1; in_req_rd_ready = '1;
    in_fsm_cmd_ready = 1'b1; in_fsm_data_ready = 1'b1; in_rd_data_valid = 1'b1;
    in_rd_data = '1; in_op_done = 1'b1;
    for (int i = 0; i < N; i++) begin
      req_op[i] = '0; req_addr[i] = '0;
    end
    step();
    step();
    chk("rst_busy", out_busy, 1'b0);
    chk("rst_cmd", {out_cmd_valid, out_cmd_opcode, out_cmd_addr}, '0);
    chk("rst_pulses", {out_req_ack, out_req_done, out_req_err}, '0);
    chk("rst_route", {out_req_wr_ready, out_req_rd_valid, out_wr_data_valid, out_rd_ready}, '0);
    chk("rst_grant", out_grant, '0);

    rst_n = 1'b1;
    in_req_valid = '0; in_req_opcode = '0; in_req_addr = '0;
    in_req_wr_valid = '0; in_req_wr_data = '0; in_req_rd_ready = '0;
    in_fsm_cmd_ready = 1'b0; in_fsm_data_ready = 1'b0; in_rd_data_valid = 1'b0;
    in_rd_data = '0; in_op_done = 1'b0;
    step();
    chk("idle_busy", out_busy, 1'b0);
    model_ptr = 0;

    // Single request with read data
    set_req(0, 2'b00, 24'h001000);
    in_req_valid = 3'b001;
    exp_idx = rr_pick(model_ptr, in_req_valid);
    start_cmd("single", exp_idx, 2, 1'b1);
    in_req_wr_valid = '0; in_req_rd_ready = 3'b001; in_fsm_data_ready = 1'b0;
    in_rd_data_valid = 1'b1; in_rd_data = 8'hA5;
    #1;
    chk("single_rd_byte", {out_req_rd_valid, out_req_rd_data}, {3'b001, 8'hA5});
    finish_busy("single", exp_idx, 3);

    // Write routing on requester 1
    set_req(1, 2'b10, 24'h0200AA);
    in_req_valid = 3'b010;
    exp_idx = rr_pick(model_ptr, in_req_valid);
    start_cmd("write", exp_idx, 0, 1'b1);
    in_req_wr_valid = 3'b011; in_req_wr_data = {8'h00, 8'h3C, 8'h77};
    in_fsm_data_ready = 1'b1; in_rd_data_valid = 1'b0; in_req_rd_ready = 3'b000;
    #1;
    chk("write_data", {out_wr_data_valid, out_wr_data}, {1'b1, 8'h3C});
    chk("write_ready", out_req_wr_ready, 3'b010);
    finish_busy("write", exp_idx, 2);

    // Round robin between two continuously valid requesters
    set_req(0, 2'b01, 24'h00A000);
    set_req(1, 2'b11, 24'h00B000);
    in_req_valid = 3'b011;
    for (int t = 0; t < 4; t++) begin
      exp_idx = rr_pick(model_ptr, in_req_valid);
      start_cmd("rr", exp_idx, t, 1'b0);
      rand_route();
      finish_busy("rr", exp_idx, t + 1);
    end
    in_req_valid = '0;

    // Watchdog expiry, then the next requester
    set_req(0, 2'b01, 24'h111111);
    set_req(1, 2'b10, 24'h222222);
    set_req(2, 2'b11, 24'h333333);
    in_req_valid = 3'b111;
    exp_idx = rr_pick(model_ptr, in_req_valid);
    start_cmd("timeout", exp_idx, 1, 1'b1);
    rand_route();
    finish_busy("timeout", exp_idx, -1);

    // op_done on the expiry cycle
    exp_idx = rr_pick(model_ptr, in_req_valid);
    start_cmd("collide", exp_idx, 0, 1'b1);
    rand_route();
    finish_busy("collide", exp_idx, TO - 1);

    // Reset during BUSY abandons the grant and clears the pointer
    exp_idx = rr_pick(model_ptr, in_req_valid);
    start_cmd("abort", exp_idx, 0, 1'b0);
    step();
    step();
    in_op_done = 1'b1;
    rst_n = 1'b0;
    step();
    chk("abort_busy", out_busy, 1'b0);
    chk("abort_pulses", {out_req_ack, out_req_done, out_req_err, out_cmd_valid}, '0);
    chk("abort_grant", out_grant, '0);
    rst_n = 1'b1;
    in_req_valid = '0;
    step();
    in_op_done = 1'b0;
    chk("abort_after", {out_busy, out_req_done, out_req_err}, '0);
    model_ptr = 0;
    in_req_valid = 3'b111;
    exp_idx = rr_pick(model_ptr, in_req_valid);
    start_cmd("post_rst", exp_idx, 1, 1'b1);
    rand_route();
    finish_busy("post_rst", exp_idx, 0);

    // Randomized traffic
    for (int t = 0; t < 12; t++) begin
      for (int i = 0; i < N; i++) begin
        if (!in_req_valid[i]) set_req(i, 2'($urandom), 24'($urandom));
      end
      in_req_valid = in_req_valid | N'($urandom);
      if (in_req_valid == '0) in_req_valid[t % N] = 1'b1;
      exp_idx = rr_pick(model_ptr, in_req_valid);
      start_cmd("rand", exp_idx, $urandom_range(0, 4), 1'b1);
      rand_route();
      finish_busy("rand", exp_idx, ($urandom_range(0, 3) == 0) ? -1 : int'($urandom_range(0, TO - 1)));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
